// File: rtl/axi_eth_rx_arb.sv
// Frame-atomic two-port round-robin arbiter merging good-frame streams toward S2MM DMA.
// Optional per-port frame counters are compiled in with `define AXI_ETH_ARB_CNT_EN.
module axi_eth_rx_arb #(
  parameter int C_DW    = 64,
  parameter int C_CNT_W = 32
) (
  input  logic                s2mm_clk,
  input  logic                s2mm_rst_n,
  input  logic [C_DW-1:0]     s0_tdata,
  input  logic [C_DW/8-1:0]   s0_tkeep,
  input  logic                s0_tlast,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [C_DW-1:0]     s1_tdata,
  input  logic [C_DW/8-1:0]   s1_tkeep,
  input  logic                s1_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  output logic [C_DW-1:0]     m_tdata,
  output logic [C_DW/8-1:0]   m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  output logic                m_tuser,
  input  logic                m_tready
`ifdef AXI_ETH_ARB_CNT_EN
  ,
  output logic [C_CNT_W-1:0]  frm_cnt0,
  output logic [C_CNT_W-1:0]  frm_cnt1,
  input  logic                cnt_clr
`endif
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last_gnt;
  logic   out_free;
  logic   acc0;
  logic   acc1;

  // Ready follows the output stage combinationally so a stalled beat blocks its source at once.
  always_comb begin
    out_free  = ~m_tvalid | m_tready;
    s0_tready = (state == GNT0) & out_free;
    s1_tready = (state == GNT1) & out_free;
    acc0      = s0_tvalid & s0_tready;
    acc1      = s1_tvalid & s1_tready;
  end

  always_ff @(posedge s2mm_clk or negedge s2mm_rst_n) begin
    if (!s2mm_rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
      m_tuser  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Under contention the port that did not win last time goes first.
          if (s0_tvalid && (!s1_tvalid || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end else if (s1_tvalid) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end
        end
        GNT0:    if (acc0 && s0_tlast) state <= IDLE;
        GNT1:    if (acc1 && s1_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (acc0) begin
        m_tdata  <= s0_tdata;
        m_tkeep  <= s0_tkeep;
        m_tlast  <= s0_tlast;
        m_tuser  <= 1'b0;
        m_tvalid <= 1'b1;
      end else if (acc1) begin
        m_tdata  <= s1_tdata;
        m_tkeep  <= s1_tkeep;
        m_tlast  <= s1_tlast;
        m_tuser  <= 1'b1;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXI_ETH_ARB_CNT_EN
  always_ff @(posedge s2mm_clk or negedge s2mm_rst_n) begin
    if (!s2mm_rst_n) begin
      frm_cnt0 <= '0;
      frm_cnt1 <= '0;
    end else if (cnt_clr) begin
      frm_cnt0 <= '0;
      frm_cnt1 <= '0;
    end else begin
      if (acc0 && s0_tlast) frm_cnt0 <= frm_cnt0 + C_CNT_W'(1);
      if (acc1 && s1_tlast) frm_cnt1 <= frm_cnt1 + C_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axi_eth_rx_arb.sv
// Scoreboard bench for axi_eth_rx_arb; counter checks are compiled in with AXI_ETH_ARB_CNT_EN.
module tb_axi_eth_rx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic [7:0]  s0_tkeep = '0, s1_tkeep = '0, m_tkeep;
  logic        s0_tlast = 1'b0, s0_tvalid = 1'b0, s0_tready;
  logic        s1_tlast = 1'b0, s1_tvalid = 1'b0, s1_tready;
  logic        m_tlast, m_tvalid, m_tuser;
  logic        m_tready = 1'b1;
`ifdef AXI_ETH_ARB_CNT_EN
  logic [31:0] frm_cnt0, frm_cnt1;
  logic        cnt_clr = 1'b0;
`endif

  axi_eth_rx_arb #(.C_DW(64), .C_CNT_W(32)) dut (
    .s2mm_clk(clk), .s2mm_rst_n(rst_n),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tready(m_tready)
`ifdef AXI_ETH_ARB_CNT_EN
    , .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .cnt_clr(cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q0[$];
  beat_t       exp_q1[$];
  int unsigned ob_cyc[$];
  logic        ob_user[$];
  logic        ob_last[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  beat_t       mon_e;
  logic        hold_pend = 1'b0;
  logic [63:0] hold_d;
  logic        hold_l, hold_u;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the expected beat of the source port named by m_tuser.
  always @(negedge clk) begin
    if (hold_pend && m_tvalid) begin
      check("hold_data", m_tdata, hold_d);
      check("hold_last", 64'(m_tlast), 64'(hold_l));
      check("hold_user", 64'(m_tuser), 64'(hold_u));
    end
    hold_pend = m_tvalid && !m_tready;
    hold_d = m_tdata;
    hold_l = m_tlast;
    hold_u = m_tuser;
    if (m_tvalid && m_tready) begin
      if ((m_tuser ? exp_q1.size() : exp_q0.size()) == 0) begin
        check("sb_unexpected_beat", 64'(m_tuser), 64'hFF);
      end else begin
        mon_e = m_tuser ? exp_q1.pop_front() : exp_q0.pop_front();
        check("m_tdata", m_tdata, mon_e.d);
        check("m_tkeep", 64'(m_tkeep), 64'(mon_e.k));
        check("m_tlast", 64'(m_tlast), 64'(mon_e.l));
      end
      ob_cyc.push_back(cyc);
      ob_user.push_back(m_tuser);
      ob_last.push_back(m_tlast);
    end
  end

  task automatic present(input int p, input int b, input int n, input logic [7:0] tag);
    beat_t bt;
    bt.d = {tag, 8'(b), 16'(p), $urandom()};
    bt.l = (b == n - 1);
    bt.k = bt.l ? 8'($urandom_range(1, 255)) : 8'hFF;
    if (p == 0) begin
      s0_tdata = bt.d; s0_tkeep = bt.k; s0_tlast = bt.l; s0_tvalid = 1'b1;
      exp_q0.push_back(bt);
    end else begin
      s1_tdata = bt.d; s1_tkeep = bt.k; s1_tlast = bt.l; s1_tvalid = 1'b1;
      exp_q1.push_back(bt);
    end
  endtask

  // Returns on the falling edge before the rising edge that accepts the beat.
  task automatic wait_accept(input int p, output bit ok);
    int guard = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!(p == 0 ? (s0_tvalid & s0_tready) : (s1_tvalid & s1_tready))) begin
      guard++;
      if (guard > 500) begin
        check("accept_timeout", 64'(p), 64'hFF);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int p, input int n, input logic [7:0] tag, output int unsigned sc);
    bit ok;
    sc = cyc;
    for (int b = 0; b < n; b++) begin
      present(p, b, n, tag);
      wait_accept(p, ok);
      if (!ok) break;
      @(posedge clk); #1;
    end
    if (p == 0) s0_tvalid = 1'b0; else s1_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check({tag, "_drain_q0"}, 64'(exp_q0.size()), 64'd0);
    check({tag, "_drain_q1"}, 64'(exp_q1.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_m_tuser"}, 64'(m_tuser), 64'd0);
    check({tag, "_m_tdata"}, m_tdata, 64'd0);
    check({tag, "_m_tkeep"}, 64'(m_tkeep), 64'd0);
    check({tag, "_s0_tready"}, 64'(s0_tready), 64'd0);
    check({tag, "_s1_tready"}, 64'(s1_tready), 64'd0);
  endtask

  task automatic do_reset();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m_tready  = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q0.delete();
    exp_q1.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Frame-level view of the output log from index nb: per-frame source, inter-frame gap, contiguity.
  task automatic check_frames(input string tag, input int nb, input int nbeats, input int nfr,
                              input logic [7:0] fuser, input bit contig);
    int f = 0;
    check({tag, "_beats"}, 64'(ob_user.size() - nb), 64'(nbeats));
    for (int i = nb; i < ob_user.size(); i++) begin
      if (i == nb || ob_last[i-1]) begin
        if (f < nfr) check({tag, "_frame_user"}, 64'(ob_user[i]), 64'(fuser[f]));
        if (i > nb) check({tag, "_gap"}, 64'(ob_cyc[i] - ob_cyc[i-1]), 64'd2);
        f++;
      end else begin
        if (f >= 1 && f <= nfr) check({tag, "_beat_user"}, 64'(ob_user[i]), 64'(fuser[f-1]));
        if (contig) check({tag, "_contig"}, 64'(ob_cyc[i] - ob_cyc[i-1]), 64'd1);
      end
    end
    check({tag, "_frames"}, 64'(f), 64'(nfr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned sc, sc1;
    int nb;
    bit ok;

    #1;
    check_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle");

    // Port 0 alone, 4 beats, sink always ready.
    nb = ob_user.size();
    send_frame(0, 4, 8'h10, sc);
    drain("t1");
    if (ob_cyc.size() > nb) check("t1_latency", 64'(ob_cyc[nb] - sc), 64'd2);
    else check("t1_no_output", 64'd0, 64'd1);
    check_frames("t1", nb, 4, 1, 8'b0, 1'b1);

    // Both ports contending from reset: P0, P1, P0, P1.
    do_reset();
    nb = ob_user.size();
    fork
      begin send_frame(0, 3, 8'h20, sc); send_frame(0, 3, 8'h21, sc); end
      begin send_frame(1, 3, 8'h22, sc1); send_frame(1, 3, 8'h23, sc1); end
    join
    drain("t2");
    check_frames("t2", nb, 12, 4, 8'b1010, 1'b1);

    // Port 1 frame under a toggling sink.
    nb = ob_user.size();
    fork
      send_frame(1, 4, 8'h30, sc);
      begin
        for (int i = 0; i < 24; i++) begin
          m_tready = (i % 2 == 0);
          @(posedge clk); #1;
        end
        m_tready = 1'b1;
      end
    join
    drain("t3");
    check_frames("t3", nb, 4, 1, 8'b1, 1'b0);

    // One-beat P0 frame while P1 waits: P0 beat, idle cycle, then P1.
    nb = ob_user.size();
    fork
      send_frame(0, 1, 8'h40, sc);
      send_frame(1, 3, 8'h41, sc1);
    join
    drain("t4");
    check_frames("t4", nb, 4, 2, 8'b10, 1'b1);

    // Reset while beat 2 of a 5-beat frame is on the output.
    present(0, 0, 5, 8'h50); wait_accept(0, ok); @(posedge clk); #1;
    present(0, 1, 5, 8'h50); wait_accept(0, ok); @(posedge clk); #1;
    check("t5_pre_valid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    s0_tvalid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    nb = ob_user.size();
    fork
      send_frame(0, 2, 8'h51, sc);
      send_frame(1, 2, 8'h52, sc1);
    join
    drain("t5");
    check_frames("t5", nb, 4, 2, 8'b10, 1'b1);

`ifdef AXI_ETH_ARB_CNT_EN
    do_reset();
    check("cnt0_rst", 64'(frm_cnt0), 64'd0);
    check("cnt1_rst", 64'(frm_cnt1), 64'd0);
    fork
      begin for (int i = 0; i < 5; i++) send_frame(0, 2, 8'h60, sc); end
      begin for (int i = 0; i < 3; i++) send_frame(1, 2, 8'h61, sc1); end
    join
    drain("t6");
    check("cnt0", 64'(frm_cnt0), 64'd5);
    check("cnt1", 64'(frm_cnt1), 64'd3);
    present(0, 0, 2, 8'h62); wait_accept(0, ok); @(posedge clk); #1;
    present(0, 1, 2, 8'h62); wait_accept(0, ok);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    s0_tvalid = 1'b0;
    check("cnt0_clr", 64'(frm_cnt0), 64'd0);
    check("cnt1_clr", 64'(frm_cnt1), 64'd0);
    drain("t7");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_eth_rx_arb.md
# axi_eth_rx_arb

Two-port, frame-atomic round-robin arbiter on the s2mm side of the 10G Ethernet receive path. It merges two already-filtered good-frame streams, one from each receive interface's good FIFO output, into one AXI4-Stream toward the S2MM DMA. The granted port is held for a whole frame and tagged on `m_tuser`. The output is a single registered stage.

## Interface
- `C_DW`, 64: data width; `tkeep` width is `C_DW/8`.
- `C_CNT_W`, 32: frame counter width (used only when counters are compiled in).
- `s2mm_clk`  in  1  single clock for the whole block.
- `s2mm_rst_n`  in  1  asynchronous, active-low reset.
- `s0_tdata` / `s0_tkeep` / `s0_tlast` / `s0_tvalid`  in  C_DW / C_DW/8 / 1 / 1  port 0 stream.
- `s0_tready`  out  1  port 0 accept.
- `s1_tdata` / `s1_tkeep` / `s1_tlast` / `s1_tvalid`  in  C_DW / C_DW/8 / 1 / 1  port 1 stream.
- `s1_tready`  out  1  port 1 accept.
- `m_tdata` / `m_tkeep` / `m_tlast` / `m_tvalid`  out  C_DW / C_DW/8 / 1 / 1  merged stream.
- `m_tuser`  out  1  source port of the current beat (0 or 1).
- `m_tready`  in  1  downstream accept.
- `frm_cnt0`, `frm_cnt1`  out  C_CNT_W  frames forwarded per port (present only with `AXI_ETH_ARB_CNT_EN`).
- `cnt_clr`  in  1  synchronous counter clear (present only with `AXI_ETH_ARB_CNT_EN`).

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE.
- `last_gnt` register; reset value is 1, so port 0 wins the first contention.
- IDLE, only `s0_tvalid` high -> GNT0. Only `s1_tvalid` high -> GNT1. Neither high -> stay in IDLE.
- IDLE, both high -> grant the port != `last_gnt`. On entering GNTx, `last_gnt` <= x.
- GNTx: `sx_tready` = `~m_tvalid | m_tready`. The other port's `tready` = 0.
- GNTx: when a beat is accepted (`sx_tvalid & sx_tready`) it loads the output register: data, keep, last, `m_tuser`=x, `m_tvalid`=1.
- GNTx: accepting a beat with `sx_tlast`=1 -> IDLE. No beat is accepted in the IDLE cycle.
- Output register: `m_tvalid` clears when `m_tready` is high and no new beat loads. Load while `m_tvalid & m_tready` is a back-to-back transfer with no bubble.
- In IDLE, both `s*_tready` = 0.
- Frames are never interleaved. `m_tuser` is constant within a frame.
- No frame inspection: `tkeep` and `tdata` pass unmodified.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tuser`=0, `m_tdata`=0, `m_tkeep`=0, `s0_tready`=0, `s1_tready`=0, counters=0.
- Arbitration: request seen in IDLE at cycle t -> GNTx at t+1 -> first beat accepted at t+1 (output free) -> `m_tvalid` at t+2.
- Throughput: 1 beat/cycle inside a frame. Exactly 1 idle arbitration cycle between frames.
- Backpressure: `m_tready` low with `m_tvalid` high -> granted `tready` low the same cycle (combinational). `m_*` stable until accepted.
- Simultaneous tlast acceptance and the other port requesting -> IDLE next cycle, then the other port is granted (round-robin).
- Reset asserted mid-frame: all state and outputs return to reset values asynchronously, and the partial frame is lost. Upstream FIFOs are reset in the same domain.

## Configuration
- `AXI_ETH_ARB_CNT_EN` defined: `frm_cnt0`/`frm_cnt1`/`cnt_clr` exist.
  - Counter x increments on acceptance of a port-x tlast beat and wraps modulo 2^C_CNT_W.
  - `cnt_clr` zeroes both counters next cycle and takes priority over a same-cycle increment.
- Not defined: the ports and counter logic are absent. Arbitration behaviour is identical.

## Test plan
- Port 0 only, 4-beat frame, `m_tready`=1 -> `m_tvalid` high 4 consecutive cycles starting 2 cycles after `s0_tvalid`; `m_tuser`=0; `m_tlast` on beat 4.
- Both ports hold 3-beat frames from reset -> order P0, P1, P0, P1. Each frame is contiguous on `m`; 1-cycle gap between frames.
- Port 1 frame with `m_tready` toggling 1,0,1,0 -> no beat dropped or duplicated; `m_*` held stable while `m_tready`=0.
- Port 0 1-beat frame (tlast on first beat) while port 1 is valid -> P0 beat, then IDLE, then P1 granted; `m_tuser` sequence 0,1.
- Reset asserted mid-frame on beat 2 of 5 -> all outputs 0 immediately. After release, port 0 is granted first under contention.
- With `AXI_ETH_ARB_CNT_EN`: 5 frames on P0 and 3 on P1 -> `frm_cnt0`=5, `frm_cnt1`=3. `cnt_clr` pulsed on a tlast cycle -> both counters 0.
